// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the bit-serial comparator.
package serial_cmp_pkg;

   // Frame controller states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Default operand width (bit-pairs per frame).
   localparam int DEFAULT_WIDTH = 4;

endpackage : serial_cmp_pkg

// File: rtl/serial_cmp_cell.sv
// One-bit decision step of the MSB-first serial comparator: the first
// differing bit-pair fixes the verdict, and later pairs leave it alone.
module serial_cmp_cell (
   input  logic a_bit_i,
   input  logic b_bit_i,
   input  logic decided_i,
   input  logic gt_i,
   input  logic lt_i,
   output logic decided_o,
   output logic gt_o,
   output logic lt_o
);

   logic settle;

   assign settle = ~decided_i & (a_bit_i ^ b_bit_i);

   // Latch the verdict on the first differing pair, otherwise hold it.
   always_comb begin
      // NOTE: every output gets a value on every path, so no latch is inferred.
      decided_o = decided_i | settle;
      gt_o      = settle ? a_bit_i : gt_i;
      lt_o      = settle ? b_bit_i : lt_i;
   end

endmodule : serial_cmp_cell

// File: rtl/serial_compare4.sv
// Bit-serial magnitude/equality comparator. Accepts WIDTH bit-pairs MSB
// first, then holds a registered verdict and the reassembled words until
// the consumer acknowledges.
module serial_compare4
   import serial_cmp_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             in_valid,
   input  logic             a_bit,
   input  logic             b_bit,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ack,
   output logic             eq,
   output logic             gt,
   output logic             lt,
   output logic [WIDTH-1:0] a_word,
   output logic [WIDTH-1:0] b_word,
   output logic             busy
);

   // Counter holds 0..WIDTH without wrapping inside a frame.
   localparam int CW = $clog2(WIDTH) + 1;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_word_q, a_word_d;
   logic [WIDTH-1:0] b_word_q, b_word_d;
   logic             decided_q, decided_d;
   logic             gt_q, gt_d;
   logic             lt_q, lt_d;

   logic accept;
   logic last_pair;
   logic cell_decided, cell_gt, cell_lt;

   assign accept    = (state_q == ST_SHIFT) & in_valid;
   assign last_pair = (cnt_q == CW'(WIDTH - 1));

   serial_cmp_cell u_cell (
      .a_bit_i   (a_bit),
      .b_bit_i   (b_bit),
      .decided_i (decided_q),
      .gt_i      (gt_q),
      .lt_i      (lt_q),
      .decided_o (cell_decided),
      .gt_o      (cell_gt),
      .lt_o      (cell_lt)
   );

   // Next-state logic of the frame controller.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (start)                state_d = ST_SHIFT;
         ST_SHIFT: if (in_valid & last_pair) state_d = ST_DONE;
         ST_DONE:  if (out_ack)              state_d = ST_IDLE;
         default:                            state_d = ST_IDLE;
      endcase
   end

   // Datapath next state: clear on frame start, shift and decide per accepted pair.
   always_comb begin
      cnt_d     = cnt_q;
      a_word_d  = a_word_q;
      b_word_d  = b_word_q;
      decided_d = decided_q;
      gt_d      = gt_q;
      lt_d      = lt_q;
      if ((state_q == ST_IDLE) && start) begin
         cnt_d     = '0;
         a_word_d  = '0;
         b_word_d  = '0;
         decided_d = 1'b0;
         gt_d      = 1'b0;
         lt_d      = 1'b0;
      end else if (accept) begin
         cnt_d     = cnt_q + CW'(1);
         a_word_d  = {a_word_q[WIDTH-2:0], a_bit};
         b_word_d  = {b_word_q[WIDTH-2:0], b_bit};
         decided_d = cell_decided;
         gt_d      = cell_gt;
         lt_d      = cell_lt;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Datapath registers; a reset discards any partial frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q     <= '0;
         a_word_q  <= '0;
         b_word_q  <= '0;
         decided_q <= 1'b0;
         gt_q      <= 1'b0;
         lt_q      <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         a_word_q  <= a_word_d;
         b_word_q  <= b_word_d;
         decided_q <= decided_d;
         gt_q      <= gt_d;
         lt_q      <= lt_d;
      end
   end

   // Handshake and status decoded straight from the state register.
   assign in_ready  = (state_q == ST_SHIFT);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);

   assign eq     = out_valid & ~decided_q;
   assign gt     = out_valid & gt_q;
   assign lt     = out_valid & lt_q;
   assign a_word = a_word_q;
   assign b_word = b_word_q;

endmodule : serial_compare4

// File: tb/tb_serial_compare4.sv
// Self-checking bench for serial_compare4: directed frames from the test
// plan plus randomized frames, checked against an integer-compare model.
module tb_serial_compare4;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         in_valid;
   logic         a_bit;
   logic         b_bit;
   logic         in_ready;
   logic         out_valid;
   logic         out_ack;
   logic         eq, gt, lt;
   logic [W-1:0] a_word;
   logic [W-1:0] b_word;
   logic         busy;

   int checks = 0;
   int errors = 0;

   serial_compare4 #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in_valid  (in_valid),
      .a_bit     (a_bit),
      .b_bit     (b_bit),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ack   (out_ack),
      .eq        (eq),
      .gt        (gt),
      .lt        (lt),
      .a_word    (a_word),
      .b_word    (b_word),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // All outputs at their reset / idle values.
   task automatic check_idle(input string tag);
      check({tag, "_busy"},   32'(busy),         32'd0);
      check({tag, "_ready"},  32'(in_ready),     32'd0);
      check({tag, "_valid"},  32'(out_valid),    32'd0);
      check({tag, "_eqgtlt"}, 32'({eq, gt, lt}), 32'd0);
   endtask

   // Drive one frame MSB first. Inputs change and outputs are sampled at the
   // falling edge. gap_mask bit c holds in_valid low in SHIFT cycle c
   // (cycle 1 is the first cycle after the start edge).
   task automatic run_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                            input int unsigned gap_mask, input bit start_in_shift,
                            input int hold, input bit start_with_ack);
      int  idx;
      int  cyc;
      bit  exp_eq, exp_gt, exp_lt;
      exp_eq = (int'(a) == int'(b));
      exp_gt = (int'(a) >  int'(b));
      exp_lt = (int'(a) <  int'(b));

      @(negedge clk);
      check("pre_busy", 32'(busy), 32'd0);
      start    = 1'b1;
      in_valid = 1'b0;
      out_ack  = 1'b0;
      @(negedge clk);
      start = 1'b0;
      idx   = 0;
      cyc   = 1;
      while (idx < W) begin
         check("shift_ready",  32'(in_ready),     32'd1);
         check("shift_busy",   32'(busy),         32'd1);
         check("shift_valid",  32'(out_valid),    32'd0);
         check("shift_eqgtlt", 32'({eq, gt, lt}), 32'd0);
         out_ack = 1'($urandom_range(0, 1));
         start   = start_in_shift && (cyc == 2);
         if (gap_mask[cyc]) begin
            in_valid = 1'b0;
            a_bit    = 1'($urandom_range(0, 1));
            b_bit    = 1'($urandom_range(0, 1));
         end else begin
            in_valid = 1'b1;
            a_bit    = a[W-1-idx];
            b_bit    = b[W-1-idx];
            idx++;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      out_ack  = 1'b0;

      check("result_valid_rise", 32'(out_valid), 32'd1);
      for (int h = 0; h <= hold; h++) begin
         check("done_valid", 32'(out_valid), 32'd1);
         check("done_busy",  32'(busy),      32'd1);
         check("done_ready", 32'(in_ready),  32'd0);
         check("eq",         32'(eq),        32'(exp_eq));
         check("gt",         32'(gt),        32'(exp_gt));
         check("lt",         32'(lt),        32'(exp_lt));
         check("a_word",     32'(a_word),    32'(a));
         check("b_word",     32'(b_word),    32'(b));
         if (h == hold) begin
            out_ack = 1'b1;
            start   = start_with_ack;
         end
         @(negedge clk);
      end
      out_ack = 1'b0;
      start   = 1'b0;
      check_idle("after_ack");
      check("after_ack_a_word", 32'(a_word), 32'(a));
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      a_bit    = 1'b0;
      b_bit    = 1'b0;
      out_ack  = 1'b0;
      #12;
      check_idle("reset");
      check("reset_a_word", 32'(a_word), 32'd0);
      check("reset_b_word", 32'(b_word), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Pairs and acks while idle are ignored.
      in_valid = 1'b1;
      a_bit    = 1'b1;
      b_bit    = 1'b0;
      out_ack  = 1'b1;
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      out_ack  = 1'b0;
      check_idle("idle_ignore");

      // Directed frames.
      run_frame(4'b0100, 4'b0100, 32'h0, 1'b0, 0, 1'b0);
      run_frame(4'd11,   4'd10,   32'h0, 1'b0, 0, 1'b0);
      run_frame(4'd8,    4'd5,    32'h0, 1'b0, 0, 1'b0);
      run_frame(4'd5,    4'd8,    32'h0, 1'b0, 0, 1'b0);
      run_frame(4'hF,    4'hE,    32'h14, 1'b1, 0, 1'b0);
      run_frame(4'd2,    4'd9,    32'h0, 1'b0, 4, 1'b1);

      // Reset in the middle of a frame.
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b1;
      a_bit    = 1'b1;
      b_bit    = 1'b0;
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      reset    = 1'b1;
      #1;
      check_idle("mid_reset");
      check("mid_reset_a_word", 32'(a_word), 32'd0);
      check("mid_reset_b_word", 32'(b_word), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run_frame(4'd3, 4'd3, 32'h0, 1'b0, 0, 1'b0);

      // Randomized frames, some with equal operands.
      for (int n = 0; n < 40; n++) begin
         ra = W'($urandom_range(0, (1 << W) - 1));
         rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom_range(0, (1 << W) - 1));
         run_frame(ra, rb, $urandom & 32'h1FE, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute time bound so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got running, expected done");
      $fatal(1, "timeout");
   end

endmodule : tb_serial_compare4

// File: doc/serial_compare4.md
# serial_compare4

Bit-serial magnitude/equality comparator: accepts two operands one bit-pair per clock, MSB first, and reports `eq`/`gt`/`lt` plus the reassembled words once all bits have arrived. It is the serial-link counterpart of the team's parallel 4-bit equality comparator. It sits at the receiving end of a serialized operand stream and hands a registered result to a downstream consumer via a valid/ack handshake.

## Interface
Reset is asynchronous and active-high.

Parameters:
- `WIDTH`, default 4: operand width, and the number of bit-pairs per frame. Must be at least 2.

Ports:
- `clk`: input, 1 bit. Single clock; all state is updated on the rising edge.
- `reset`: input, 1 bit. Asynchronous, active-high; returns the block to IDLE.
- `start`: input, 1 bit. Begins a frame; sampled only in IDLE.
- `in_valid`: input, 1 bit. The `a_bit`/`b_bit` pair is valid this cycle.
- `a_bit`: input, 1 bit. Current bit of operand A, MSB first.
- `b_bit`: input, 1 bit. Current bit of operand B, MSB first.
- `in_ready`: output, 1 bit. The block accepts bit-pairs; high only in SHIFT.
- `out_valid`: output, 1 bit. Result is valid; high only in DONE.
- `out_ack`: input, 1 bit. The consumer takes the result.
- `eq`, `gt`, `lt`: output, 1 bit each. Comparison of A against B; exactly one is high while `out_valid` is high.
- `a_word`: output, WIDTH bits. Reassembled operand A.
- `b_word`: output, WIDTH bits. Reassembled operand B.
- `busy`: output, 1 bit. Block is not in IDLE.

## Operation
- FSM states:
  - IDLE, reset state. `start`=1 → SHIFT. Bit counter cleared to 0, decided flag cleared, shift registers cleared.
  - SHIFT. A bit-pair is accepted on each cycle with `in_valid`=1. The counter increments on every accepted pair. On the WIDTH-th accepted pair → DONE.
  - DONE. Results are held stable. `out_ack`=1 → IDLE.
- Per accepted pair, while the decided flag is 0 and `a_bit`≠`b_bit`:
  - Set the decided flag.
  - Set `gt_r` = `a_bit`.
  - Set `lt_r` = `b_bit`.
  - Once decided, later bits do not change the verdict.
- Every accepted pair shifts in: `a_word` ← {`a_word`[WIDTH-2:0], `a_bit`}, and likewise for `b_word`.
- `eq` = `out_valid` & ~decided. `gt`/`lt` are gated by `out_valid`. All three read 0 outside DONE.
- A frame always consumes exactly WIDTH pairs; there is no early termination, even after the verdict is decided.
- `in_valid` while not in SHIFT is ignored.
- `start` while not in IDLE is ignored.
- Reset values: `in_ready`=0, `out_valid`=0, `eq`=`gt`=`lt`=0, `a_word`=`b_word`=0, `busy`=0, counter=0.

## Timing
- `in_ready`, `out_valid`, and `busy` are decoded directly from the state register: combinational from flops, no input-to-output paths.
- Latency with `start` at edge 0 and `in_valid` held high:
  - SHIFT from cycle 1.
  - Last pair accepted at cycle WIDTH.
  - `out_valid` from cycle WIDTH+1.
- `in_valid` gaps stall the counter and extend latency one cycle per gap.
- `out_ack` sampled with `out_valid` high → `out_valid` low the next cycle. A `start` in that same cycle is ignored; `start` must be presented in IDLE.
- `out_ack` with `out_valid` low: no effect.
- Counter wrap: the counter is $clog2(WIDTH)+1 bits wide and never wraps within a frame. It is cleared on entry to SHIFT.
- Reset mid-frame, in any state: immediate return to IDLE and all outputs to their reset values. The partial frame is discarded.

## Structure
- Shared package `serial_cmp_pkg`:
  - State enum (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - Default WIDTH constant.
- One sub-module, `serial_cmp_cell`:
  - Combinational one-bit decision step.
  - Inputs: `a_bit`, `b_bit`, decided, `gt_r`, `lt_r`.
  - Outputs: next decided, next `gt_r`, next `lt_r`.
- The top level holds the FSM, counter, shift registers, and verdict flops.

## Test plan
- A=4'b0100, B=4'b0100, continuous `in_valid` → `out_valid` at cycle 5; `eq`=1, `gt`=`lt`=0; `a_word`=`b_word`=4'h4.
- A=11, B=10 → `gt`=1, decided on LSB (4th pair); `a_word`=4'hB, `b_word`=4'hA.
- A=8, B=5, then A=5, B=8 in two back-to-back frames → `gt`=1 then `lt`=1, each decided on the 1st pair. The bits of the second frame after its 1st pair do not change its verdict.
- A=4'hF, B=4'hE with `in_valid` low on cycles 2 and 4 → `out_valid` at cycle 7, `gt`=1; `start` pulsed during SHIFT is ignored.
- Reset asserted after 2 pairs → all outputs 0 and `busy`=0 at once. A following frame A=3, B=3 → `eq`=1.
- `out_valid` held for 5 cycles with no `out_ack` → results stable throughout; `out_ack` → IDLE the next cycle.
